// File: rtl/gate_pkg.sv
// Shared definitions for the gate logic unit: operation encodings, default
// operand width and the output-buffer occupancy states.
package gate_pkg;

    localparam int GATE_WIDTH_DEFAULT = 8;
    localparam int GATE_OP_W          = 3;

    typedef enum logic [GATE_OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // Occupancy of the 2-entry output buffer.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/gate_op.sv
// Combinational bitwise gate: applies the selected operation across all
// WIDTH bits of A and B. Kept standalone so gate-level benches can reuse it.
module gate_op
    import gate_pkg::*;
#(
    parameter int WIDTH = GATE_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [GATE_OP_W-1:0] OP,
    output logic [WIDTH-1:0]     X
);

    // Operation decode; B is unused by NOT A and PASS A.
    always_comb begin
        X = '0;
        case (op_e'(OP))
            OP_AND:  X = A & B;
            OP_OR:   X = A | B;
            OP_XOR:  X = A ^ B;
            OP_NAND: X = ~(A & B);
            OP_NOR:  X = ~(A | B);
            OP_XNOR: X = ~(A ^ B);
            OP_NOTA: X = ~A;
            OP_PASS: X = A;
            default: X = '0;
        endcase
    end

endmodule

// File: rtl/gate_logic_unit.sv
// Gate logic unit: accepts (A, B, OP) with a valid/ready handshake, computes
// the bitwise result and queues it in a 2-entry buffer. The head of the buffer
// is presented on X with its AND/OR/XOR reductions, and completed output
// handshakes are counted in TXN_CNT.
module gate_logic_unit
    import gate_pkg::*;
#(
    parameter int WIDTH = GATE_WIDTH_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [GATE_OP_W-1:0] OP,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [WIDTH-1:0]     X,
    output logic                 RED_AND,
    output logic                 RED_OR,
    output logic                 RED_XOR,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [CNT_W-1:0]     TXN_CNT
);

    occ_e             occ;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    // Result is computed from the operands offered this cycle, so OP is
    // captured per transaction along with A and B.
    gate_op #(
        .WIDTH(WIDTH)
    ) u_gate_op (
        .A (A),
        .B (B),
        .OP(OP),
        .X (result)
    );

    // Ready depends only on registered occupancy and reset, never on OUT_READY.
    assign IN_READY  = (occ != OCC_TWO) && !RST;
    assign OUT_VALID = (occ != OCC_EMPTY);
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;

    // Head is kept at zero whenever the buffer is empty, so X and the
    // reductions of zero (all 0) fall out directly without extra muxing.
    assign X       = head;
    assign RED_AND = &head;
    assign RED_OR  = |head;
    assign RED_XOR = ^head;
    assign TXN_CNT = cnt;

    // Buffer occupancy FSM with head/tail storage and the completion counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            occ  <= OCC_EMPTY;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (pop) begin
                cnt <= cnt + CNT_W'(1);
            end
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        head <= result;
                        occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail <= result;
                            occ  <= OCC_TWO;
                        end
                        2'b01: begin
                            head <= '0;
                            occ  <= OCC_EMPTY;
                        end
                        2'b11: begin
                            // Head leaves and the new result takes its place.
                            head <= result;
                        end
                        default: begin
                            head <= head;
                        end
                    endcase
                end
                OCC_TWO: begin
                    // IN_READY is low here, so only a pop can occur.
                    if (pop) begin
                        head <= tail;
                        tail <= '0;
                        occ  <= OCC_ONE;
                    end
                end
                default: begin
                    occ  <= OCC_EMPTY;
                    head <= '0;
                    tail <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_logic_unit.sv
// Self-checking bench for gate_logic_unit (WIDTH=8, CNT_W=16): directed
// vectors, hand-written buffer corner cases, randomized traffic against a
// queue-based reference model, and counter wrap.
module tb_gate_logic_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic        red_and;
    logic        red_or;
    logic        red_xor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] txn_cnt;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] x;
    } vec_t;

    vec_t        tbl[8];
    logic [7:0]  q[$];
    logic [15:0] exp_cnt;
    logic [7:0]  r0, r1, r2;

    gate_logic_unit #(
        .WIDTH(8),
        .CNT_W(16)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .A        (a),
        .B        (b),
        .OP       (op),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .X        (x),
        .RED_AND  (red_and),
        .RED_OR   (red_or),
        .RED_XOR  (red_xor),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .TXN_CNT  (txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference gate: each op is a 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [7:0] ref_op(input logic [7:0] ra, input logic [7:0] rb,
                                          input logic [2:0] rop);
        logic [3:0] tt;
        logic [7:0] r;
        case (rop)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0110;
            3'd3: tt = 4'b0111;
            3'd4: tt = 4'b0001;
            3'd5: tt = 4'b1001;
            3'd6: tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 8; i++) r[i] = tt[{ra[i], rb[i]}];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Compare every output against what a buffer holding 'q' should present.
    task automatic check_outputs(input string tag);
        logic [7:0] hx;
        int         ones;
        hx   = (q.size() != 0) ? q[0] : 8'h00;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(hx[i]);
        check({tag, " out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        check({tag, " x"},         32'(x),         32'(hx));
        check({tag, " red_and"},   32'(red_and),   32'(hx == 8'hFF));
        check({tag, " red_or"},    32'(red_or),    32'(hx != 8'h00));
        check({tag, " red_xor"},   32'(red_xor),   32'(ones % 2));
        check({tag, " txn_cnt"},   32'(txn_cnt),   32'(exp_cnt));
        check({tag, " in_ready"},  32'(in_ready),  32'(!rst && q.size() < 2));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vop);
        a        = va;
        b        = vb;
        op       = vop;
        in_valid = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_cnt   = '0;
        rst       = 1'b1;
        a         = '0;
        b         = '0;
        op        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        tbl[0] = '{8'hA5, 8'h3C, 3'd0, 8'h24};
        tbl[1] = '{8'hA5, 8'h3C, 3'd1, 8'hBD};
        tbl[2] = '{8'hA5, 8'h3C, 3'd2, 8'h99};
        tbl[3] = '{8'hA5, 8'h3C, 3'd3, 8'hDB};
        tbl[4] = '{8'hA5, 8'h3C, 3'd4, 8'h42};
        tbl[5] = '{8'hA5, 8'h3C, 3'd5, 8'h66};
        tbl[6] = '{8'hA5, 8'h3C, 3'd6, 8'h5A};
        tbl[7] = '{8'hA5, 8'h3C, 3'd7, 8'hA5};

        // Reset state
        tick();
        tick();
        check("rst in_ready",  32'(in_ready),  32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst x",         32'(x),         32'd0);
        check("rst txn_cnt",   32'(txn_cnt),   32'd0);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        // Single AND transaction, one-cycle latency
        offer(8'hF0, 8'hCC, 3'd0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("and out_valid", 32'(out_valid), 32'd1);
        check("and x",         32'(x),         32'hC0);
        check("and red_and",   32'(red_and),   32'd0);
        check("and red_or",    32'(red_or),    32'd1);
        check("and red_xor",   32'(red_xor),   32'd0);
        tick();
        check("and txn_cnt",   32'(txn_cnt),   32'd1);
        check("and drained",   32'(out_valid), 32'd0);
        check("and x zero",    32'(x),         32'd0);

        // All eight ops back to back, streaming through occupancy ONE
        for (int i = 0; i < 8; i++) begin
            offer(tbl[i].a, tbl[i].b, tbl[i].op);
            tick();
            check($sformatf("op%0d x", i), 32'(x), 32'(tbl[i].x));
            check($sformatf("op%0d ref", i), 32'(ref_op(tbl[i].a, tbl[i].b, tbl[i].op)),
                  32'(tbl[i].x));
        end
        in_valid = 1'b0;
        tick();
        check("ops txn_cnt", 32'(txn_cnt), 32'd9);

        // Stall: three offers with OUT_READY low, then drain in order
        r0 = ref_op(8'h12, 8'h34, 3'd2);
        r1 = ref_op(8'hFF, 8'h0F, 3'd0);
        r2 = ref_op(8'h81, 8'h00, 3'd6);
        out_ready = 1'b0;
        offer(8'h12, 8'h34, 3'd2);
        tick();
        check("stall ready1", 32'(in_ready), 32'd1);
        offer(8'hFF, 8'h0F, 3'd0);
        tick();
        check("stall ready2", 32'(in_ready), 32'd0);
        check("stall x0",     32'(x),        32'(r0));
        offer(8'h81, 8'h00, 3'd6);
        tick();
        check("stall held",     32'(in_ready), 32'd0);
        check("stall x0 again", 32'(x),        32'(r0));
        op = 3'd7;
        tick();
        check("stall x0 op change", 32'(x), 32'(r0));
        op = 3'd6;
        out_ready = 1'b1;
        tick();
        check("drain x1",     32'(x),        32'(r1));
        check("drain ready",  32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("drain x2",     32'(x),        32'(r2));
        check("drain valid2", 32'(out_valid), 32'd1);
        tick();
        check("drain empty",  32'(out_valid), 32'd0);
        check("drain cnt",    32'(txn_cnt),   32'd12);

        // Simultaneous push and pop at occupancy ONE
        out_ready = 1'b0;
        offer(8'h0F, 8'h33, 3'd1);
        tick();
        out_ready = 1'b1;
        offer(8'h55, 8'hAA, 3'd5);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pp x",     32'(x),         32'(ref_op(8'h55, 8'hAA, 3'd5)));
        check("pp valid", 32'(out_valid), 32'd1);
        check("pp ready", 32'(in_ready),  32'd1);
        check("pp cnt",   32'(txn_cnt),   32'd13);

        // Reset while full, with handshakes offered during reset
        offer(8'h01, 8'h02, 3'd1);
        tick();
        check("full ready", 32'(in_ready), 32'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst-full in_ready", 32'(in_ready), 32'd0);
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst-full valid", 32'(out_valid), 32'd0);
        check("rst-full x",     32'(x),         32'd0);
        check("rst-full cnt",   32'(txn_cnt),   32'd0);
        check("rst-full ready", 32'(in_ready),  32'd1);

        // Randomized traffic against the queue model
        q.delete();
        exp_cnt = '0;
        for (int i = 0; i < 2000; i++) begin
            logic do_push;
            logic do_pop;
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom);
            #1;
            check_outputs($sformatf("rnd%0d", i));
            do_push = in_valid && !rst && q.size() < 2;
            do_pop  = out_ready && q.size() != 0;
            tick();
            if (rst) begin
                q.delete();
                exp_cnt = '0;
            end else begin
                if (do_pop) begin
                    void'(q.pop_front());
                    exp_cnt++;
                end
                if (do_push) q.push_back(ref_op(a, b, op));
            end
        end

        // Counter wrap over 65536 completions
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        offer(8'h3C, 8'hC3, 3'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) tick();
        check("wrap pre", 32'(txn_cnt), 32'hFFFF);
        tick();
        check("wrap zero", 32'(txn_cnt), 32'd0);
        in_valid = 1'b0;
        tick();
        check("wrap drain", 32'(txn_cnt), 32'd1);
        check("wrap empty", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_logic_unit.md
GATE_LOGIC_UNIT -- requirements
Module: gate_logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 SHALL have parameter CNT_W, default 16, giving the completed-transaction counter width.
REQ-003 SHALL have port CLK  input  1  the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port RST  input  1  reset: one clock, reset synchronous and active-high.
REQ-005 SHALL have port A  input  WIDTH  first operand.
REQ-006 SHALL have port B  input  WIDTH  second operand.
REQ-007 SHALL have port OP  input  3  operation select, sampled with A and B.
REQ-008 SHALL have port IN_VALID  input  1  upstream offers A/B/OP.
REQ-009 SHALL have port IN_READY  output  1  the block can accept this cycle.
REQ-010 SHALL have port X  output  WIDTH  result at the head of the output buffer.
REQ-011 SHALL have port RED_AND, RED_OR, RED_XOR  output  1 each  AND, OR and XOR reductions of X.
REQ-012 SHALL have port OUT_VALID  output  1  X and the reduction flags are valid.
REQ-013 SHALL have port OUT_READY  input  1  downstream consumes the head.
REQ-014 SHALL have port TXN_CNT  output  CNT_W  count of completed output handshakes.

Function
REQ-015 SHALL decode OP as follows: 000 AND; 001 OR; 010 XOR; 011 NAND; 100 NOR; 101 XNOR; 110 NOT A (B ignored); 111 PASS A.
REQ-016 SHALL accept an input only when IN_VALID and IN_READY are both 1 at a rising edge; it SHALL then compute the result bitwise over WIDTH bits and write it to a 2-entry FIFO.
REQ-017 SHALL drive IN_READY = (occupancy != 2) && !RST, decoded from registered state only with no combinational path from OUT_READY.
REQ-018 SHALL use occupancy states EMPTY, ONE and TWO with these transitions:
- push only: EMPTY->ONE, ONE->TWO.
- pop only: TWO->ONE, ONE->EMPTY.
- push and pop together in ONE: stays ONE, and the head is replaced by the new result.
- pop when EMPTY, or push when TWO: impossible by the handshake rules.
REQ-019 SHALL assert OUT_VALID exactly when occupancy != EMPTY, so latency from input acceptance to OUT_VALID is 1 cycle when the FIFO is empty.
REQ-020 SHALL treat a pop as OUT_VALID && OUT_READY at a rising edge, and SHALL deliver results in acceptance order.
REQ-021 SHALL hold X and the RED_* flags stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 SHALL drive X=0 and RED_* = RED_AND 0, RED_OR 0, RED_XOR 0 whenever OUT_VALID=0.
REQ-023 SHALL increment TXN_CNT by 1 on each pop, wrapping from 2^CNT_W-1 to 0 with no saturation.
REQ-024 SHALL sample OP per transaction, so a change of OP never alters results already buffered.

Reset
REQ-025 SHALL, on any rising edge with RST=1 (including mid-operation), set occupancy to EMPTY, OUT_VALID 0, X 0, RED_* 0 and TXN_CNT 0, and discard buffered entries.
REQ-026 SHALL hold IN_READY at 0 while RST=1, and drive it to 1 in the first cycle after RST falls.
REQ-027 SHALL ignore any input handshake or output handshake presented in a cycle with RST=1.

Structure
REQ-028 SHALL take the OP encodings (OP_AND..OP_PASS) and the default WIDTH from a shared package, gate_pkg.
REQ-029 SHALL instantiate a single combinational sub-module, gate_op (parameter WIDTH; ports A, B, OP, X), which the testbenches of the basic gates SHALL reuse.

Verification (WIDTH=8)
REQ-030 SHALL cover: reset, then A=0xF0, B=0xCC, OP=AND with OUT_READY=1 -> next cycle OUT_VALID=1, X=0xC0, RED_AND=0, RED_OR=1, RED_XOR=0, and TXN_CNT=1 after the pop.
REQ-031 SHALL cover: A=0xA5, B=0x3C through OP 000..111 -> X = 0x24, 0xBD, 0x99, 0xDB, 0x42, 0x66, 0x5A, 0xA5 in order.
REQ-032 SHALL cover: OUT_READY=0 and three back-to-back offers -> IN_READY=0 after two accepts and the third is held; then OUT_READY=1 -> all three emerge in order with X stable while stalled.
REQ-033 SHALL cover: occupancy ONE with simultaneous push and pop -> occupancy stays ONE, the new result appears next cycle and TXN_CNT increments by 1.
REQ-034 SHALL cover: RST pulsed for 1 cycle while occupancy is TWO -> next cycle OUT_VALID=0, X=0, TXN_CNT=0 and IN_READY=1.
REQ-035 SHALL cover: 65536 consecutive transactions with CNT_W=16 -> TXN_CNT wraps to 0.
